// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet framing constants, CRC-32 step function and receive framer types.
package eth_pkg;
  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} rx_state_e;
  typedef struct packed {
    logic ok;
    logic crc_err;
    logic len_err;
    logic phy_err;
    logic ovf;
  } rx_stat_t;
  // Bits enter LSB first into an MSB-shifting register, so a good frame leaves the
  // bit-reversed form of the familiar 0xDEBB20E3 residue.
  function automatic logic [31:0] next_crc32_d8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC32_POLY : 32'h0);
    return r;
  endfunction
endpackage

// File: rtl/sf_frame_fifo.sv
// sf_frame_fifo: store-and-forward byte buffer with commit/rewind on the write side
// and a registered valid/ready read port that prefetches one byte per clock.
module sf_frame_fifo #(
  parameter int DEPTH = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_i,
  input  logic [8:0] wr_data_i,
  input  logic       commit_i,
  input  logic       rewind_i,
  output logic       full_o,
  output logic [8:0] rd_data_o,
  output logic       rd_valid_o,
  input  logic       rd_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [8:0] mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_q, rd_ptr_q;
  logic [8:0] dout_q;
  logic valid_q, rd_en;
  assign full_o = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  assign wr_ptr_d = rewind_i ? commit_q : wr_ptr_q + (AW+1)'(wr_en_i);
  // Only committed bytes are readable; the output register doubles as the RAM read stage.
  assign rd_en = (rd_ptr_q != commit_q) && (!valid_q || rd_ready_i);
  assign rd_data_o = dout_q;
  assign rd_valid_o = valid_q;
  always_ff @(posedge clk)
    if (wr_en_i && !rewind_i) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      commit_q <= '0;
      rd_ptr_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (commit_i) commit_q <= wr_ptr_d;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q <= mem[rd_ptr_q[AW-1:0]];
      end
      valid_q <= rd_en || (valid_q && !rd_ready_i);
    end
endmodule

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: GMII receive framer; strips preamble/SFD, checks FCS and length,
// and forwards only good frames (FCS removed) through a store-and-forward buffer.
module gmii_rx_framer
  import eth_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] gmii_rxd_i,
  input  logic       gmii_rx_dv_i,
  input  logic       gmii_rx_er_i,
  output logic [7:0] rd_data_o,
  output logic       rd_last_o,
  output logic       rd_valid_o,
  input  logic       rd_ready_i,
  output logic       stat_ok_o,
  output logic       stat_crc_err_o,
  output logic       stat_len_err_o,
  output logic       stat_phy_err_o,
  output logic       stat_ovf_o
);
  rx_state_e state_q, state_d;
  rx_stat_t stat_q, stat_d;
  logic [31:0] crc_q, crc_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0] pre_q, pre_d, hbn_q, hbn_d;
  logic [4:0][7:0] hb_q, hb_d;
  logic wr_en, wr_last, commit, rewind, full, hb_full;
  logic [8:0] rdata;
  assign hb_full = hbn_q == 3'd5;
  // The last four bytes of a frame are its FCS, so data trails the wire by a 5-byte holdback.
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    cnt_d = cnt_q;
    pre_d = pre_q;
    hbn_d = hbn_q;
    hb_d = hb_q;
    stat_d = '0;
    wr_en = 1'b0;
    wr_last = 1'b0;
    commit = 1'b0;
    rewind = 1'b0;
    case (state_q)
      ST_IDLE:
        if (gmii_rx_dv_i) begin
          state_d = gmii_rxd_i == ETH_PREAMBLE ? ST_PRE : ST_DROP;
          pre_d = 3'd1;
        end
      ST_PRE:
        if (!gmii_rx_dv_i) state_d = ST_IDLE;
        else if (gmii_rxd_i == ETH_SFD) begin
          state_d = ST_DATA;
          crc_d = CRC32_INIT;
          cnt_d = '0;
          hbn_d = '0;
        end else if (gmii_rxd_i == ETH_PREAMBLE && pre_q != 3'd7) pre_d = pre_q + 3'd1;
        else state_d = ST_DROP;
      ST_DATA:
        if (!gmii_rx_dv_i) begin
          state_d = ST_IDLE;
          if (cnt_q < 12'(MIN_LEN)) stat_d.len_err = 1'b1;
          else if (crc_q != CRC32_RESIDUE) stat_d.crc_err = 1'b1;
          else if (full) stat_d.ovf = 1'b1;
          else begin
            wr_en = 1'b1;
            wr_last = 1'b1;
            commit = 1'b1;
            stat_d.ok = 1'b1;
          end
          rewind = !commit;
        end else if (gmii_rx_er_i || (hb_full && full) || cnt_q == 12'(MAX_LEN)) begin
          state_d = ST_DROP;
          rewind = 1'b1;
          stat_d.phy_err = gmii_rx_er_i;
          stat_d.ovf = !gmii_rx_er_i && hb_full && full;
          stat_d.len_err = !gmii_rx_er_i && !(hb_full && full);
        end else begin
          crc_d = next_crc32_d8(gmii_rxd_i, crc_q);
          cnt_d = cnt_q + 12'd1;
          hb_d = {hb_q[3:0], gmii_rxd_i};
          hbn_d = hb_full ? hbn_q : hbn_q + 3'd1;
          wr_en = hb_full;
        end
      default:
        if (!gmii_rx_dv_i) begin
          state_d = ST_IDLE;
          rewind = 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      stat_q <= '0;
      crc_q <= CRC32_INIT;
      cnt_q <= '0;
      pre_q <= '0;
      hbn_q <= '0;
      hb_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q <= stat_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      hbn_q <= hbn_d;
      hb_q <= hb_d;
    end
  sf_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en_i(wr_en),
    .wr_data_i({wr_last, hb_q[4]}),
    .commit_i(commit),
    .rewind_i(rewind),
    .full_o(full),
    .rd_data_o(rdata),
    .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i)
  );
  assign {rd_last_o, rd_data_o} = rdata;
  assign stat_ok_o = stat_q.ok;
  assign stat_crc_err_o = stat_q.crc_err;
  assign stat_len_err_o = stat_q.len_err;
  assign stat_phy_err_o = stat_q.phy_err;
  assign stat_ovf_o = stat_q.ovf;
endmodule
